// File: rtl/reg_file_pkg.sv
// Shared constants and helpers for the architectural register file.
// Holds the register-count and index-width values that the rest of the core
// uses, alongside the ROB tag range.
package reg_file_pkg;

  // ROB geometry: ROBSize entries addressed by a ROBRange-wide tag
  localparam int ROB_RANGE_W = 4;
  localparam int ROB_SIZE    = 16;

  // Architectural register geometry
  localparam int REG_NUM   = 32;
  localparam int REG_IDX_W = 5;
  localparam int XLEN      = 32;
  localparam int CNT_W     = 6;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  // Population count of a busy vector, sized for the busy counter
  function automatic logic [CNT_W-1:0] busy_popcount(input logic [REG_NUM-1:0] vec);
    logic [CNT_W-1:0] cnt;
    cnt = {CNT_W{1'b0}};
    for (int i = 0; i < REG_NUM; i++) begin
      cnt = cnt + {{(CNT_W-1){1'b0}}, vec[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/reg_read_port.sv
// One operand read port: selects a register's busy/tag/value and bypasses a
// same-cycle commit that retires the mapping the register is waiting on.
module reg_read_port
  import reg_file_pkg::*;
#(
  parameter int ROB_TAG_W = ROB_RANGE_W,
  parameter int NREG      = REG_NUM
) (
  input  logic [REG_IDX_W-1:0]             idx,
  input  logic [NREG-1:0]                  busy_vec,
  input  logic [NREG-1:0][ROB_TAG_W-1:0]   tag_vec,
  input  logic [NREG-1:0][XLEN-1:0]        val_vec,
  input  logic                             commit_valid,
  input  logic [REG_IDX_W-1:0]             commit_rd,
  input  logic [ROB_TAG_W-1:0]             commit_rdTag,
  input  logic [XLEN-1:0]                  commit_rdVal,
  output logic                             busy,
  output logic [ROB_TAG_W-1:0]             tag,
  output logic [XLEN-1:0]                  val
);

  logic hit_s;

  // Bypass only when the commit retires exactly the mapping being waited on
  always_comb begin
    hit_s = FALSE;
    if (commit_valid && (commit_rd == idx) && busy_vec[idx] &&
        (tag_vec[idx] == commit_rdTag)) begin
      hit_s = TRUE;
    end else begin
      hit_s = FALSE;
    end
  end

  // Operand mux: x0 is constant zero, then bypass, then stored state
  always_comb begin
    busy = 1'b0;
    tag  = {ROB_TAG_W{1'b0}};
    val  = {XLEN{1'b0}};
    if (idx == {REG_IDX_W{1'b0}}) begin
      busy = 1'b0;
      tag  = {ROB_TAG_W{1'b0}};
      val  = {XLEN{1'b0}};
    end else if (hit_s) begin
      busy = 1'b0;
      tag  = tag_vec[idx];
      val  = commit_rdVal;
    end else begin
      busy = busy_vec[idx];
      tag  = tag_vec[idx];
      val  = val_vec[idx];
    end
  end

endmodule

// File: rtl/reg_file.sv
// Architectural register file with rename tags. Records renames at issue,
// retires values at commit, drops all pending renames on rollback, and
// serves two combinational operand reads with commit bypass.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int ROB_TAG_W = ROB_RANGE_W,
  parameter int NREG      = REG_NUM
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  input  logic                   issue_valid,
  input  logic [REG_IDX_W-1:0]   issue_rd,
  input  logic [ROB_TAG_W-1:0]   issue_tag,
  input  logic [REG_IDX_W-1:0]   rs1_idx,
  input  logic [REG_IDX_W-1:0]   rs2_idx,
  output logic                   rs1_busy,
  output logic                   rs2_busy,
  output logic [ROB_TAG_W-1:0]   rs1_tag,
  output logic [ROB_TAG_W-1:0]   rs2_tag,
  output logic [XLEN-1:0]        rs1_val,
  output logic [XLEN-1:0]        rs2_val,
  input  logic                   commit_valid,
  input  logic [REG_IDX_W-1:0]   commit_rd,
  input  logic [ROB_TAG_W-1:0]   commit_rdTag,
  input  logic [XLEN-1:0]        commit_rdVal,
  input  logic                   rollback,
  output logic [CNT_W-1:0]       busy_count
);

  logic [NREG-1:0]                busy_r;
  logic [NREG-1:0][ROB_TAG_W-1:0] tag_r;
  logic [NREG-1:0][XLEN-1:0]      val_r;
  logic [CNT_W-1:0]               busy_count_r;

  logic [NREG-1:0]                busy_nxt_s;
  logic [NREG-1:0][ROB_TAG_W-1:0] tag_nxt_s;
  logic [NREG-1:0][XLEN-1:0]      val_nxt_s;

  // Next state: commit writes value and retires a matching rename; rollback
  // then overrides issue for busy/tag. Entry 0 is always forced to zero.
  always_comb begin
    busy_nxt_s = busy_r;
    tag_nxt_s  = tag_r;
    val_nxt_s  = val_r;
    if (rdy) begin
      if (commit_valid && (commit_rd != {REG_IDX_W{1'b0}})) begin
        val_nxt_s[commit_rd] = commit_rdVal;
        if (busy_r[commit_rd] && (tag_r[commit_rd] == commit_rdTag)) begin
          busy_nxt_s[commit_rd] = 1'b0;
        end else begin
          busy_nxt_s[commit_rd] = busy_r[commit_rd];
        end
      end else begin
        val_nxt_s = val_r;
      end
      if (rollback) begin
        busy_nxt_s = {NREG{1'b0}};
      end else if (issue_valid && (issue_rd != {REG_IDX_W{1'b0}})) begin
        busy_nxt_s[issue_rd] = 1'b1;
        tag_nxt_s[issue_rd]  = issue_tag;
      end else begin
        tag_nxt_s = tag_r;
      end
    end else begin
      busy_nxt_s = busy_r;
    end
    busy_nxt_s[0] = 1'b0;
    tag_nxt_s[0]  = {ROB_TAG_W{1'b0}};
    val_nxt_s[0]  = {XLEN{1'b0}};
  end

  // State registers and busy counter tracking the next busy vector
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_r       <= {NREG{1'b0}};
      tag_r        <= {(NREG*ROB_TAG_W){1'b0}};
      val_r        <= {(NREG*XLEN){1'b0}};
      busy_count_r <= {CNT_W{1'b0}};
    end else begin
      busy_r       <= busy_nxt_s;
      tag_r        <= tag_nxt_s;
      val_r        <= val_nxt_s;
      busy_count_r <= busy_popcount(busy_nxt_s);
    end
  end

  assign busy_count = busy_count_r;

  reg_read_port #(.ROB_TAG_W(ROB_TAG_W), .NREG(NREG)) u_rs1 (
    .idx          (rs1_idx),
    .busy_vec     (busy_r),
    .tag_vec      (tag_r),
    .val_vec      (val_r),
    .commit_valid (commit_valid),
    .commit_rd    (commit_rd),
    .commit_rdTag (commit_rdTag),
    .commit_rdVal (commit_rdVal),
    .busy         (rs1_busy),
    .tag          (rs1_tag),
    .val          (rs1_val)
  );

  reg_read_port #(.ROB_TAG_W(ROB_TAG_W), .NREG(NREG)) u_rs2 (
    .idx          (rs2_idx),
    .busy_vec     (busy_r),
    .tag_vec      (tag_r),
    .val_vec      (val_r),
    .commit_valid (commit_valid),
    .commit_rd    (commit_rd),
    .commit_rdTag (commit_rdTag),
    .commit_rdVal (commit_rdVal),
    .busy         (rs2_busy),
    .tag          (rs2_tag),
    .val          (rs2_val)
  );

endmodule
